// File: rtl/snake_input_timer.sv
// snake_input_timer: debounced button direction queue with paced game tick and free-running LED tick.
module snake_input_timer #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int TICK_PERIOD     = 33_554_432,
    parameter int LED_DIV         = 32,
    parameter int QDEPTH          = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    reset_n,
    input  logic [3:0]              btn_n,
    input  logic [1:0]              speed,
    input  logic                    pause,
    output logic                    game_tick,
    output logic                    led_tick,
    output logic [31:0]             direction,
    output logic                    dir_valid,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    overflow
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TICK_PERIOD);
    localparam int LW = $clog2(LED_DIV);
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;

    logic [3:0]    s1, s2, deb, arm, hit, fall;
    logic [1:0]    warm, sel, dir_idx, spd_q, eff;
    logic [DW-1:0] dcnt [4];
    logic [1:0]    q [QDEPTH];
    logic [QW-1:0] rp, wp;
    logic [TW-1:0] tcnt, term;
    logic [LW-1:0] lcnt;
    logic          ref_axis, ref_ok, accept, wrap, pop, push, full;

    always_comb begin
        for (int i = 0; i < 4; i++)
            hit[i] = s2[i] != deb[i] && dcnt[i] == DW'(DEBOUNCE_CYCLES - 1);
    end

    assign fall = hit & deb & arm;
    assign sel = fall[0] ? 2'd0 : fall[1] ? 2'd1 : fall[2] ? 2'd2 : 2'd3;
    // equal and opposite directions share bit 1 of the index encoding
    assign ref_axis = q_count != '0 ? q[wp - QW'(1)][1] : dir_idx[1];
    assign ref_ok = q_count != '0 || dir_valid;
    assign accept = |fall && !(ref_ok && sel[1] == ref_axis);
    assign eff = tcnt == '0 ? speed : spd_q;
    assign term = TW'((TICK_PERIOD >> eff) - 1);
    assign wrap = !pause && tcnt == term;
    assign pop = wrap && q_count != '0;
    assign full = q_count == CW'(QDEPTH);
    assign push = accept && (!full || pop);
    assign direction = !dir_valid ? 32'h0 :
                       dir_idx == 2'd0 ? 32'h20DF6A95 :
                       dir_idx == 2'd1 ? 32'h20DFEA15 :
                       dir_idx == 2'd2 ? 32'h20DF9A65 : 32'h20DF1AE5;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '1;
            s2   <= '1;
            deb  <= '1;
            arm  <= '0;
            warm <= '0;
            for (int i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            s1   <= btn_n;
            s2   <= s1;
            warm <= {warm[0], 1'b1};
            // a button held through reset stays disarmed until it is first seen released
            arm  <= arm | (warm[1] ? s2 : 4'b0);
            for (int i = 0; i < 4; i++) begin
                dcnt[i] <= s2[i] != deb[i] && !hit[i] ? dcnt[i] + DW'(1) : '0;
                if (hit[i]) deb[i] <= s2[i];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tcnt      <= '0;
            spd_q     <= '0;
            game_tick <= 1'b0;
            lcnt      <= '0;
            led_tick  <= 1'b0;
            rp        <= '0;
            wp        <= '0;
            q_count   <= '0;
            dir_idx   <= '0;
            dir_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tcnt      <= wrap ? '0 : pause ? tcnt : tcnt + TW'(1);
            if (tcnt == '0 && !pause) spd_q <= speed;
            game_tick <= wrap;
            lcnt      <= lcnt + LW'(1);
            led_tick  <= lcnt == LW'(LED_DIV - 1);
            if (pop) begin
                dir_idx   <= q[rp];
                dir_valid <= 1'b1;
                rp        <= rp + QW'(1);
            end
            if (push) wp <= wp + QW'(1);
            if (accept && full && !pop) overflow <= 1'b1;
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) q[wp] <= sel;
    end
endmodule

// File: tb/tb_snake_input_timer.sv
// tb_snake_input_timer: randomized button stimulus against a queue-based reference model with a tick scoreboard.
module tb_snake_input_timer;
    localparam int DEB = 4, TP = 64, LD = 4, QD = 2;

    logic        clk = 1'b0, rst_n = 1'b0, pause = 1'b0;
    logic [3:0]  btn = 4'hF;
    logic [1:0]  speed = 2'd0;
    logic        game_tick, led_tick, dir_valid, overflow;
    logic [31:0] direction;
    logic [1:0]  q_count;
    int          passed = 0, total = 0;
    logic [31:0] codes [4] = '{32'h20DF6A95, 32'h20DFEA15, 32'h20DF9A65, 32'h20DF1AE5};

    typedef struct { logic [31:0] d; logic v; int qc; logic o; } exp_t;
    exp_t sb [$];
    logic exp_gt = 1'b0, exp_led = 1'b0;

    snake_input_timer #(.DEBOUNCE_CYCLES(DEB), .TICK_PERIOD(TP), .LED_DIV(LD), .QDEPTH(QD)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .btn_n(btn), .speed(speed), .pause(pause),
        .game_tick(game_tick), .led_tick(led_tick), .direction(direction),
        .dir_valid(dir_valid), .q_count(q_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h, expected %0h", n, a, e);
    endtask

    // Reference model: sync delay, "last DEB samples all differ" debounce, queue of button indices.
    initial begin : model
        logic [3:0] my1, my2, s, lev, arm, fl;
        logic [3:0] hist [$];
        int mq [$];
        int mdir, rem, lcyc, edges, sel, refd;
        logic mval, movf, need, refok, acc, popping, full, allx;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                my1 = '1; my2 = '1; lev = '1; arm = '0;
                hist.delete(); mq.delete(); sb.delete();
                mdir = 0; mval = 0; movf = 0; need = 1; rem = 0; lcyc = 0; edges = 0;
                exp_gt = 0; exp_led = 0;
            end else begin
                edges++;
                s = my2; my2 = my1; my1 = btn;
                hist.push_back(s);
                if (hist.size() > DEB) void'(hist.pop_front());
                fl = '0;
                for (int i = 0; i < 4; i++) begin
                    allx = hist.size() == DEB;
                    foreach (hist[k]) if (hist[k][i] == lev[i]) allx = 0;
                    if (allx) begin
                        lev[i] = ~lev[i];
                        fl[i] = ~lev[i] & arm[i];
                    end
                    if (edges >= 3 && s[i]) arm[i] = 1;
                end
                exp_gt = 0;
                if (!pause) begin
                    if (need) begin
                        rem = TP >> speed;
                        need = 0;
                    end
                    rem--;
                    if (rem == 0) begin
                        exp_gt = 1;
                        need = 1;
                    end
                end
                sel = 0;
                while (sel < 3 && !fl[sel]) sel++;
                refok = mq.size() > 0 || mval;
                refd = mq.size() > 0 ? mq[$] : mdir;
                acc = fl != 0 && !(refok && sel / 2 == refd / 2);
                popping = exp_gt && mq.size() > 0;
                full = mq.size() == QD;
                if (popping) begin
                    mdir = mq.pop_front();
                    mval = 1;
                end
                if (acc) begin
                    if (!full || popping) mq.push_back(sel);
                    else movf = 1;
                end
                if (exp_gt) sb.push_back('{mval ? codes[mdir] : 32'h0, mval, mq.size(), movf});
                lcyc++;
                exp_led = lcyc % LD == 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("game_tick", game_tick, exp_gt);
                chk("led_tick", led_tick, exp_led);
                if (game_tick) begin
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL tick_scoreboard: got game_tick, expected none pending");
                    end else begin
                        e = sb.pop_front();
                        chk("direction", direction, e.d);
                        chk("dir_valid", dir_valid, e.v);
                        chk("q_count", q_count, e.qc);
                        chk("overflow", overflow, e.o);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m, input int bounce, input int hold);
        for (int b = 0; b < bounce; b++) begin
            btn = btn & ~m; cyc(1);
            btn = btn | m;  cyc(1);
        end
        btn = btn & ~m; cyc(hold);
        for (int b = 0; b < bounce; b++) begin
            btn = btn | m;  cyc(1);
            btn = btn & ~m; cyc(1);
        end
        btn = btn | m; cyc(hold);
    endtask

    task automatic reset_check();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_direction", direction, 32'h0);
        chk("rst_dir_valid", dir_valid, 1'b0);
        chk("rst_q_count", q_count, 2'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_game_tick", game_tick, 1'b0);
        chk("rst_led_tick", led_tick, 1'b0);
        cyc(3);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [3:0] m;
        reset_check();
        press(4'b0100, 2, DEB + 4);
        cyc(70);
        press(4'b1000, 0, DEB + 3);
        press(4'b0001, 0, DEB + 3);
        cyc(70);
        press(4'b0100, 0, DEB + 2);
        press(4'b0001, 0, DEB + 2);
        press(4'b0100, 0, DEB + 2);
        cyc(150);
        speed = 2'd2; cyc(60);
        pause = 1'b1; cyc(40);
        pause = 1'b0; cyc(60);
        speed = 2'd0;
        press(4'b0100, 0, DEB + 2);
        press(4'b0001, 0, DEB + 2);
        btn[1] = 1'b0;
        reset_check();
        cyc(DEB + 10);
        btn[1] = 1'b1;
        cyc(10);
        press(4'b1001, 1, DEB + 3);
        cyc(80);
        for (int it = 0; it < 40; it++) begin
            m = 4'b1 << $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) m = m | (4'b1 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
            pause = $urandom_range(0, 5) == 0;
            press(m, $urandom_range(0, 2), DEB + 2 + $urandom_range(0, 10));
            cyc($urandom_range(0, 20));
        end
        pause = 1'b0;
        cyc(100);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/snake_input_timer.md
SNAKE_INPUT_TIMER -- requirements
Module: snake_input_timer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500_000: consecutive stable cycles needed to accept a button level change.
REQ-002 Parameter TICK_PERIOD, default 33_554_432: game tick period in CLOCK_50 cycles at speed 0.
REQ-003 Parameter LED_DIV, default 32: led_tick period in cycles; power of two, at least 2.
REQ-004 Parameter QDEPTH, default 4: direction command queue depth; power of two, at least 2.
REQ-005 CLOCK_50  in  1  sole clock; all state on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 btn_n  in  4  raw active-low buttons, asynchronous to CLOCK_50; [0]=UP, [1]=DOWN, [2]=RIGHT, [3]=LEFT.
REQ-008 speed  in  2  tick rate select; period = TICK_PERIOD >> speed.
REQ-009 pause  in  1  high freezes the game tick counter.
REQ-010 game_tick  out  1  one-cycle pulse per game step.
REQ-011 led_tick  out  1  one-cycle pulse every LED_DIV cycles.
REQ-012 direction  out  32  current direction code: UP=20DF6A95h, DOWN=20DFEA15h, LEFT=20DF1AE5h, RIGHT=20DF9A65h; 0 = none yet.
REQ-013 dir_valid  out  1  high once direction holds a real code.
REQ-014 q_count  out  $clog2(QDEPTH)+1  entries pending in the queue.
REQ-015 overflow  out  1  sticky flag; a press was dropped because the queue was full.

Function
REQ-016 Each btn_n bit passes a 2-FF synchroniser before any other logic.
REQ-017 Debounced level per button changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts that button's count.
REQ-018 Press event = debounced level going 1->0; one cycle wide; holding a button produces no further events.
REQ-019 Same-cycle press events: only the highest priority is taken, UP > DOWN > RIGHT > LEFT; the others are discarded.
REQ-020 Reference direction = last queued entry if queue non-empty, else current direction.
REQ-021 A press equal or opposite to the reference direction is discarded; with no reference (dir_valid=0, queue empty), every press is accepted.
REQ-022 Accepted press with queue full (q_count=QDEPTH and no pop that cycle): dropped, overflow set.
REQ-023 Queue full and a pop in the same cycle: push accepted; q_count unchanged.
REQ-024 Tick counter counts 0..(TICK_PERIOD>>speed)-1 and wraps; game_tick=1 in the cycle after the counter reaches its terminal value.
REQ-025 speed is sampled only at the wrap; a mid-period change affects the next period only.
REQ-026 pause=1: counter holds; no game_tick; queue pushes continue; pops stop.
REQ-027 Pop happens at the same edge that raises game_tick when q_count>0.
REQ-028 On a pop, direction and dir_valid=1 are registered together with game_tick=1, so direction is stable throughout the tick cycle.
REQ-029 Queue empty at a tick: direction holds.
REQ-030 led_tick comes from a free-running counter independent of pause and speed; first pulse LED_DIV cycles after reset release.

Reset
REQ-031 reset_n low, at any time including mid-debounce or mid-period, immediately forces:
- direction=0, dir_valid=0, q_count=0, overflow=0
- game_tick=0, led_tick=0
- all counters 0
- debounced levels=1 (released)
- synchronisers=1
REQ-032 After release: first game_tick TICK_PERIOD>>speed cycles later; no press event from buttons already held through reset until they are released and pressed again.

Verification (DEBOUNCE_CYCLES=4, TICK_PERIOD=64, LED_DIV=4, QDEPTH=2)
REQ-033 Press btn_n[2] with 2-cycle bounce, then stable -> single event; at the next tick direction=20DF9A65h, dir_valid=1.
REQ-034 Direction RIGHT, press LEFT then UP -> LEFT discarded, UP queued; next tick direction=20DF6A95h, q_count 1->0.
REQ-035 btn_n[0] and btn_n[3] falling in the same cycle -> only UP queued; q_count=1.
REQ-036 Three accepted presses with no tick in between -> q_count=2, overflow=1; overflow stays 1 after the queue drains.
REQ-037 speed=2 at steady state -> tick spacing 16 cycles; pause for 40 cycles -> no ticks, counter value preserved; led_tick every 4 cycles throughout.
REQ-038 reset_n low mid-period with q_count=2 -> all outputs at reset values within the same cycle; first tick 64 cycles after release.
